// File: rtl/dfr_pkg.sv
// Shared types and constants for the DFR run sequencer.
package dfr_pkg;

  localparam int DEF_CNT_WIDTH = 32;

  localparam logic [1:0] PH_IDLE  = 2'd0;
  localparam logic [1:0] PH_INIT  = 2'd1;
  localparam logic [1:0] PH_TRAIN = 2'd2;
  localparam logic [1:0] PH_TEST  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_LOAD,
    ST_STEP,
    ST_NEXT,
    ST_DONE
  } state_t;

  function automatic logic [1:0] phase_after(input logic [1:0] ph);
    return ph + 2'd1;
  endfunction

endpackage

// File: rtl/dfr_phase_sequencer_if.sv
// Datapath handshake between the run sequencer (master) and the DFR datapath (slave).
interface dfr_phase_sequencer_if #(
  parameter int SAMPLE_ADDR_WIDTH = 16,
  parameter int OUT_ADDR_WIDTH    = 16
);

  logic                         sample_req;
  logic [SAMPLE_ADDR_WIDTH-1:0] sample_addr;
  logic                         sample_ack;
  logic                         step_en;
  logic                         step_ack;
  logic                         out_wen;
  logic [OUT_ADDR_WIDTH-1:0]    out_addr;

  modport master (
    output sample_req, sample_addr, step_en, out_wen, out_addr,
    input  sample_ack, step_ack
  );

  modport slave (
    input  sample_req, sample_addr, step_en, out_wen, out_addr,
    output sample_ack, step_ack
  );

endinterface

// File: rtl/dfr_phase_counter.sv
// Per-phase sample, step and per-sample step counters; shared by all three phases.
module dfr_phase_counter
  import dfr_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 sample_inc,
  input  logic                 step_inc,
  input  logic                 spp_clr,
  input  logic [CNT_WIDTH-1:0] sample_cap,
  input  logic [CNT_WIDTH-1:0] step_cap,
  input  logic [CNT_WIDTH-1:0] spp_cap,
  output logic                 sample_last,
  output logic                 step_last,
  output logic                 step_full,
  output logic                 spp_last
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] sample_cnt;
  logic [CNT_WIDTH-1:0] step_cnt;
  logic [CNT_WIDTH-1:0] spp_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt <= '0;
      step_cnt   <= '0;
      spp_cnt    <= '0;
    end else if (clr) begin
      sample_cnt <= '0;
      step_cnt   <= '0;
      spp_cnt    <= '0;
    end else begin
      if (sample_inc) sample_cnt <= sample_cnt + ONE;
      if (step_inc)   step_cnt   <= step_cnt + ONE;
      if (spp_clr)       spp_cnt <= '0;
      else if (step_inc) spp_cnt <= spp_cnt + ONE;
    end
  end

  // "last" flags look one increment ahead so the FSM can decide in the same cycle it counts.
  assign sample_last = (sample_cnt + ONE) == sample_cap;
  assign step_last   = (step_cnt + ONE) == step_cap;
  assign spp_last    = (spp_cnt + ONE) == spp_cap;
  assign step_full   = step_cnt == step_cap;

endmodule

// File: rtl/dfr_phase_sequencer.sv
// DFR run controller: walks init/train/test, fetching samples, stepping the reservoir
// and addressing the node-output capture memory.
//
// state | meaning
// IDLE  | waiting for start
// SEL   | pick current phase, skip it if it has no samples or no steps
// LOAD  | sample_req high until sample_ack
// STEP  | step_en high until step_ack, capture node output in train/test
// NEXT  | advance to next sample or finish the phase
// DONE  | one-cycle done pulse
module dfr_phase_sequencer
  import dfr_pkg::*;
#(
  parameter int SAMPLE_ADDR_WIDTH = 16,
  parameter int OUT_ADDR_WIDTH    = 16,
  parameter int CNT_WIDTH         = DEF_CNT_WIDTH
) (
  input  logic                 S_AXI_ACLK,
  input  logic                 S_AXI_ARESETN,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_init_samples,
  input  logic [CNT_WIDTH-1:0] num_init_steps,
  input  logic [CNT_WIDTH-1:0] num_train_samples,
  input  logic [CNT_WIDTH-1:0] num_train_steps,
  input  logic [CNT_WIDTH-1:0] num_test_samples,
  input  logic [CNT_WIDTH-1:0] num_test_steps,
  input  logic [CNT_WIDTH-1:0] num_steps_per_sample,
  output logic                 busy,
  output logic [1:0]           phase,
  output logic                 done,
  dfr_phase_sequencer_if.master dp
);

  state_t state_q, state_d;
  logic [1:0] phase_q, phase_d;

  logic [CNT_WIDTH-1:0] sh_init_samples, sh_init_steps;
  logic [CNT_WIDTH-1:0] sh_train_samples, sh_train_steps;
  logic [CNT_WIDTH-1:0] sh_test_samples, sh_test_steps;
  logic [CNT_WIDTH-1:0] sh_spp;

  logic [CNT_WIDTH-1:0] cur_samples, cur_steps;

  logic [SAMPLE_ADDR_WIDTH-1:0] sample_addr_q;
  logic [OUT_ADDR_WIDTH-1:0]    out_addr_q;

  logic load_shadow, cnt_clr, sample_inc, step_inc, spp_clr, saddr_inc, oaddr_inc;
  logic sample_last, step_last, step_full, spp_last;

  always_comb begin
    cur_samples = '0;
    cur_steps   = '0;
    case (phase_q)
      PH_INIT:  begin cur_samples = sh_init_samples;  cur_steps = sh_init_steps;  end
      PH_TRAIN: begin cur_samples = sh_train_samples; cur_steps = sh_train_steps; end
      PH_TEST:  begin cur_samples = sh_test_samples;  cur_steps = sh_test_steps;  end
      default:  begin cur_samples = '0;               cur_steps = '0;             end
    endcase
  end

  dfr_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk         (S_AXI_ACLK),
    .rst_n       (S_AXI_ARESETN),
    .clr         (cnt_clr),
    .sample_inc  (sample_inc),
    .step_inc    (step_inc),
    .spp_clr     (spp_clr),
    .sample_cap  (cur_samples),
    .step_cap    (cur_steps),
    .spp_cap     (sh_spp),
    .sample_last (sample_last),
    .step_last   (step_last),
    .step_full   (step_full),
    .spp_last    (spp_last)
  );

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= ST_IDLE;
      phase_q <= PH_IDLE;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    load_shadow = 1'b0;
    cnt_clr     = 1'b0;
    sample_inc  = 1'b0;
    step_inc    = 1'b0;
    spp_clr     = 1'b0;
    saddr_inc   = 1'b0;
    oaddr_inc   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load_shadow = 1'b1;
          cnt_clr     = 1'b1;
          state_d     = ST_SEL;
          phase_d     = PH_INIT;
        end
      end
      ST_SEL: begin
        if (cur_samples == '0 || cur_steps == '0) begin
          if (phase_q == PH_TEST) state_d = ST_DONE;
          else                    phase_d = phase_after(phase_q);
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (dp.sample_ack) state_d = (sh_spp == '0) ? ST_NEXT : ST_STEP;
      end
      ST_STEP: begin
        if (dp.step_ack) begin
          step_inc = 1'b1;
          if (phase_q != PH_INIT) oaddr_inc = 1'b1;
          if (step_last || spp_last) state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        saddr_inc  = 1'b1;
        sample_inc = 1'b1;
        spp_clr    = 1'b1;
        // step_full here means the step cap was hit in STEP: the phase is exhausted.
        if (step_full || sample_last) begin
          cnt_clr = 1'b1;
          if (phase_q == PH_TEST) begin
            state_d = ST_DONE;
          end else begin
            phase_d = phase_after(phase_q);
            state_d = ST_SEL;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
      end
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sh_init_samples  <= '0;
      sh_init_steps    <= '0;
      sh_train_samples <= '0;
      sh_train_steps   <= '0;
      sh_test_samples  <= '0;
      sh_test_steps    <= '0;
      sh_spp           <= '0;
    end else if (load_shadow) begin
      sh_init_samples  <= num_init_samples;
      sh_init_steps    <= num_init_steps;
      sh_train_samples <= num_train_samples;
      sh_train_steps   <= num_train_steps;
      sh_test_samples  <= num_test_samples;
      sh_test_steps    <= num_test_steps;
      sh_spp           <= num_steps_per_sample;
    end
  end

  // Addresses wrap silently; sample_addr runs continuously across all phases.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      sample_addr_q <= '0;
      out_addr_q    <= '0;
    end else if (load_shadow) begin
      sample_addr_q <= '0;
      out_addr_q    <= '0;
    end else begin
      if (saddr_inc) sample_addr_q <= sample_addr_q + SAMPLE_ADDR_WIDTH'(1);
      if (oaddr_inc) out_addr_q    <= out_addr_q + OUT_ADDR_WIDTH'(1);
    end
  end

  assign busy           = state_q != ST_IDLE;
  assign phase          = phase_q;
  assign done           = state_q == ST_DONE;
  assign dp.sample_req  = state_q == ST_LOAD;
  assign dp.sample_addr = sample_addr_q;
  assign dp.step_en     = state_q == ST_STEP;
  assign dp.out_wen     = (state_q == ST_STEP) && dp.step_ack && (phase_q != PH_INIT);
  assign dp.out_addr    = out_addr_q;

endmodule

// File: tb/tb_dfr_phase_sequencer.sv
// Bench for dfr_phase_sequencer: transaction-level expected-operation model plus directed runs.
module tb_dfr_phase_sequencer;
  import dfr_pkg::*;

  localparam int SAW = 4;
  localparam int OAW = 3;
  localparam int CW  = 32;
  localparam int K_SEL = 0, K_LOAD = 1, K_STEP = 2, K_NEXT = 3, K_DONE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [CW-1:0] n_is, n_ic, n_ts, n_tc, n_xs, n_xc, n_spp;
  logic busy, done;
  logic [1:0] phase;

  dfr_phase_sequencer_if #(.SAMPLE_ADDR_WIDTH(SAW), .OUT_ADDR_WIDTH(OAW)) dp ();

  dfr_phase_sequencer #(.SAMPLE_ADDR_WIDTH(SAW), .OUT_ADDR_WIDTH(OAW), .CNT_WIDTH(CW)) dut (
    .S_AXI_ACLK           (clk),
    .S_AXI_ARESETN        (rst_n),
    .start                (start),
    .num_init_samples     (n_is),
    .num_init_steps       (n_ic),
    .num_train_samples    (n_ts),
    .num_train_steps      (n_tc),
    .num_test_samples     (n_xs),
    .num_test_steps       (n_xc),
    .num_steps_per_sample (n_spp),
    .busy                 (busy),
    .phase                (phase),
    .done                 (done),
    .dp                   (dp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Expected operation list for one run, built from the phase rules.
  typedef struct {
    int kind;
    int ph;
    int sa;
    int oa;
    bit wen;
  } op_t;
  op_t q[$];

  function automatic void push_op(input int kind, input int ph, input int sa, input int oa, input bit wen);
    op_t o;
    o.kind = kind; o.ph = ph; o.sa = sa; o.oa = oa; o.wen = wen;
    q.push_back(o);
  endfunction

  function automatic void build_model();
    int unsigned smp[3];
    int unsigned cap[3];
    int unsigned spp, sa, oa, steps;
    bit exh;
    smp[0] = n_is; cap[0] = n_ic;
    smp[1] = n_ts; cap[1] = n_tc;
    smp[2] = n_xs; cap[2] = n_xc;
    spp = n_spp; sa = 0; oa = 0;
    q.delete();
    for (int p = 0; p < 3; p++) begin
      push_op(K_SEL, p + 1, 0, 0, 1'b0);
      if (smp[p] == 0 || cap[p] == 0) continue;
      steps = 0; exh = 1'b0;
      for (int unsigned s = 0; s < smp[p] && !exh; s++) begin
        push_op(K_LOAD, p + 1, int'(sa % (1 << SAW)), 0, 1'b0);
        for (int unsigned k = 0; k < spp && !exh; k++) begin
          push_op(K_STEP, p + 1, 0, int'(oa % (1 << OAW)), p != 0);
          if (p != 0) oa++;
          steps++;
          if (steps == cap[p]) exh = 1'b1;
        end
        push_op(K_NEXT, p + 1, 0, 0, 1'b0);
        sa++;
      end
    end
    push_op(K_DONE, 3, 0, 0, 1'b0);
  endfunction

  // Per-run observations of the DUT, for the literal expectations.
  int n_req, n_step, n_wen, n_done, n_busy, last_oaddr, last_saddr, first_ph, first_sa;
  bit have_first;

  op_t cur;
  bit  adv;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_phase", phase, 0);
      chk("rst_done", done, 0);
      chk("rst_sample_req", dp.sample_req, 0);
      chk("rst_sample_addr", dp.sample_addr, 0);
      chk("rst_step_en", dp.step_en, 0);
      chk("rst_out_wen", dp.out_wen, 0);
      chk("rst_out_addr", dp.out_addr, 0);
      q.delete();
    end else begin
      if (q.size() == 0) begin
        chk("idle_busy", busy, 0);
        chk("idle_phase", phase, 0);
        chk("idle_done", done, 0);
        chk("idle_sample_req", dp.sample_req, 0);
        chk("idle_step_en", dp.step_en, 0);
        chk("idle_out_wen", dp.out_wen, 0);
        if (start) begin
          build_model();
          n_req = 0; n_step = 0; n_wen = 0; n_done = 0; n_busy = 0;
          last_oaddr = -1; last_saddr = -1; first_ph = -1; first_sa = -1; have_first = 1'b0;
        end
      end else begin
        cur = q[0];
        chk("busy", busy, 1);
        chk("phase", phase, cur.ph);
        chk("sample_req", dp.sample_req, cur.kind == K_LOAD);
        chk("step_en", dp.step_en, cur.kind == K_STEP);
        chk("done", done, cur.kind == K_DONE);
        chk("out_wen", dp.out_wen, (cur.kind == K_STEP) && dp.step_ack && cur.wen);
        if (cur.kind == K_LOAD) chk("sample_addr", dp.sample_addr, cur.sa);
        if (cur.kind == K_STEP && dp.step_ack && cur.wen) chk("out_addr", dp.out_addr, cur.oa);
        adv = 1'b1;
        if (cur.kind == K_LOAD) adv = dp.sample_ack;
        if (cur.kind == K_STEP) adv = dp.step_ack;
        if (adv) void'(q.pop_front());
      end
      if (busy) n_busy++;
      if (done) n_done++;
      if (dp.sample_req && dp.sample_ack) begin
        n_req++;
        last_saddr = int'(dp.sample_addr);
        if (!have_first) begin
          have_first = 1'b1; first_ph = int'(phase); first_sa = int'(dp.sample_addr);
        end
      end
      if (dp.step_en && dp.step_ack) n_step++;
      if (dp.out_wen) begin
        n_wen++;
        last_oaddr = int'(dp.out_addr);
      end
    end
  end

  // Datapath responder: ack after a configurable delay, optionally with stray acks.
  int ack_fix = 1;
  bit spurious = 1'b0;
  int s_age = 0, s_d = 0, t_age = 0, t_d = 0;
  bit s_seen = 1'b0, s_ack = 1'b0, t_seen = 1'b0, t_ack = 1'b0;

  always @(posedge clk) begin
    #1;
    if (!dp.sample_req || !s_seen || s_ack) begin
      s_age = 0;
      s_d = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 2));
    end else s_age++;
    s_ack = dp.sample_req ? (s_age >= s_d) : (spurious && ($urandom_range(0, 3) == 0));
    s_seen = dp.sample_req;
    dp.sample_ack = s_ack;

    if (!dp.step_en || !t_seen || t_ack) begin
      t_age = 0;
      t_d = (ack_fix >= 0) ? ack_fix : int'($urandom_range(0, 2));
    end else t_age++;
    t_ack = dp.step_en ? (t_age >= t_d) : (spurious && ($urandom_range(0, 3) == 0));
    t_seen = dp.step_en;
    dp.step_ack = t_ack;
  end

  task automatic set_counts(input int is, input int ic, input int ts, input int tc,
                            input int xs, input int xc, input int sp);
    n_is = CW'(is); n_ic = CW'(ic); n_ts = CW'(ts); n_tc = CW'(tc);
    n_xs = CW'(xs); n_xc = CW'(xc); n_spp = CW'(sp);
  endtask

  task automatic start_run(input int is, input int ic, input int ts, input int tc,
                           input int xs, input int xc, input int sp);
    @(posedge clk); #1;
    set_counts(is, ic, ts, tc, xs, xc, sp);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for the run to end; with perturb, count inputs churn and start re-pulses while busy.
  task automatic wait_run(input bit perturb);
    bit fin = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      if (perturb) begin
        n_is = $urandom; n_ic = $urandom; n_ts = $urandom; n_tc = $urandom;
        n_xs = $urandom; n_xc = $urandom; n_spp = $urandom;
        start = ($urandom_range(0, 5) == 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    chk("run_completes", fin, 1);
  endtask

  task automatic do_run(input int is, input int ic, input int ts, input int tc,
                        input int xs, input int xc, input int sp, input bit perturb);
    start_run(is, ic, ts, tc, xs, xc, sp);
    wait_run(perturb);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    dp.sample_ack = 1'b0;
    dp.step_ack = 1'b0;
    set_counts(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Nominal run, with mid-run start pulses and count churn that must be ignored.
    ack_fix = 1; spurious = 1'b0;
    do_run(2, 4, 3, 6, 1, 2, 2, 1'b1);
    chk("t1_sample_reqs", n_req, 6);
    chk("t1_step_acks", n_step, 12);
    chk("t1_out_wens", n_wen, 8);
    chk("t1_last_out_addr", last_oaddr, 7);
    chk("t1_last_sample_addr", last_saddr, 5);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_busy_after", busy, 0);

    // Init skipped, train capped at 3 steps part way through its second sample.
    do_run(0, 4, 3, 3, 0, 0, 2, 1'b0);
    chk("t2_first_req_phase", first_ph, 2);
    chk("t2_first_req_addr", first_sa, 0);
    chk("t2_sample_reqs", n_req, 2);
    chk("t2_out_wens", n_wen, 3);
    chk("t2_last_out_addr", last_oaddr, 2);

    // Everything zero: three skips plus DONE.
    do_run(0, 0, 0, 0, 0, 0, 0, 1'b0);
    chk("t3_busy_cycles", n_busy, 4);
    chk("t3_done_pulses", n_done, 1);
    chk("t3_sample_reqs", n_req, 0);
    chk("t3_step_acks", n_step, 0);

    // Reset while step_en is high aborts without a done pulse.
    ack_fix = 2;
    start_run(2, 4, 3, 6, 1, 2, 2);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dp.step_en) begin
        seen = 1'b1;
        break;
      end
    end
    chk("t4_step_en_seen", seen, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_async_busy", busy, 0);
    chk("t4_async_step_en", dp.step_en, 0);
    chk("t4_async_phase", phase, 0);
    chk("t4_async_sample_addr", dp.sample_addr, 0);
    @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("t4_no_done_after_abort", n_done, 0);
    ack_fix = 1;
    do_run(1, 1, 1, 1, 0, 0, 1, 1'b0);
    chk("t4_restart_first_addr", first_sa, 0);
    chk("t4_restart_sample_reqs", n_req, 2);
    chk("t4_restart_out_addr", last_oaddr, 0);
    chk("t4_restart_done", n_done, 1);

    // Randomised runs against the model, with random ack latency and stray acks.
    ack_fix = -1; spurious = 1'b1;
    for (int r = 0; r < 30; r++) begin
      do_run(int'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8)),
             int'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8)),
             int'($urandom_range(0, 6)), ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, 8)),
             int'($urandom_range(0, 3)), 1'b1);
      chk("rand_done_pulses", n_done, 1);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dfr_phase_sequencer.md
Name: dfr_phase_sequencer

Overview:
Run controller for the delayed-feedback reservoir (DFR) datapath. The AXI config-register block supplies a start pulse and sample/step counts. This block then sequences the three phases (init, train, test): it fetches input samples, issues reservoir step strobes and addresses the node-output capture memory. Its busy output feeds ctrl bit 1 of the register block, and its done pulse feeds the host status path.

Parameters:
SAMPLE_ADDR_WIDTH, 16, width of input-sample memory address
OUT_ADDR_WIDTH, 16, width of node-output capture memory address
CNT_WIDTH, 32, width of all count inputs and internal counters

Ports:
S_AXI_ACLK  in  1  system clock
S_AXI_ARESETN  in  1  reset; asynchronous, active-low
start  in  1  one-cycle start pulse (ctrl bit 0)
num_init_samples  in  CNT_WIDTH  samples in init phase
num_init_steps  in  CNT_WIDTH  step cap for init phase
num_train_samples  in  CNT_WIDTH  samples in train phase
num_train_steps  in  CNT_WIDTH  step cap for train phase
num_test_samples  in  CNT_WIDTH  samples in test phase
num_test_steps  in  CNT_WIDTH  step cap for test phase
num_steps_per_sample  in  CNT_WIDTH  reservoir steps per sample
busy  out  1  run in progress
phase  out  2  0 idle, 1 init, 2 train, 3 test
sample_req  out  1  request to load the sample at sample_addr
sample_addr  out  SAMPLE_ADDR_WIDTH  global sample index
sample_ack  in  1  sample latched by datapath
step_en  out  1  request one reservoir step
step_ack  in  1  step complete
out_wen  out  1  one-cycle capture strobe for node output
out_addr  out  OUT_ADDR_WIDTH  capture address
done  out  1  one-cycle run-complete pulse

Behaviour:
- Reset is asynchronous and active-low. While S_AXI_ARESETN=0, all outputs are 0, the FSM is in IDLE and all counters are cleared. Reset mid-run aborts the run immediately and no done pulse follows.
- Count inputs are sampled into shadow registers on the accepted start edge. Later changes to the inputs have no effect on the current run.
- FSM states are IDLE, SEL, LOAD, STEP, NEXT, DONE.
- IDLE: waits for start. On start, shadows load and sample_addr, out_addr and all counters clear; the FSM goes to SEL with phase=init. busy=1 from the cycle after start.
- start while busy=1 is ignored.
- SEL: if the current phase has samples==0 or step cap==0, the phase is skipped and the FSM advances to the next phase, staying in SEL. After test, the FSM goes to DONE. Otherwise the FSM goes to LOAD. Each skipped phase costs 1 cycle.
- LOAD: sample_req is held high until sample_ack. In the ack cycle, sample_req drops and the FSM goes to STEP. If num_steps_per_sample==0, the FSM goes to NEXT instead.
- STEP: step_en is held high until step_ack.
  - On step_ack in train or test: out_wen pulses for 1 cycle, in the ack cycle, with the current out_addr; out_addr then increments.
  - On step_ack: the phase step counter and the per-sample step counter increment.
  - If the phase step counter reaches its cap, the FSM goes to NEXT with the phase marked exhausted.
  - Else, if the per-sample counter reaches num_steps_per_sample, the FSM goes to NEXT.
  - Else the FSM stays in STEP; step_en may stay high back-to-back.
- NEXT: sample_addr increments and the phase sample counter increments.
  - If the phase is exhausted, or the sample counter equals the phase sample count, the phase counters clear and the FSM goes to SEL for the next phase.
  - Otherwise the FSM goes to LOAD.
- DONE: done=1 for 1 cycle, then IDLE with busy=0 and phase=0. busy falls in the same edge that leaves DONE.
- sample_addr and out_addr wrap modulo 2^width with no error. sample_addr is continuous across phases; init samples are not captured.
- An ack arriving while the corresponding request is low is ignored.

Decomposition:
- Package dfr_pkg holds: the state enum (IDLE..DONE), the phase encoding constants (PH_IDLE=0, PH_INIT=1, PH_TRAIN=2, PH_TEST=3), and the CNT_WIDTH default.
- One sub-module, dfr_phase_counter: holds the sample and step counters for a phase, with clear and increment inputs and cap-reached outputs. It is instantiated once and reused across phases.

Test Plan:
- Counts init 2/4, train 3/6, test 1/2, steps_per_sample=2, acks returned 1 cycle after each request -> 6 sample_req, 12 step_en, 8 out_wen at out_addr 0..7, sample_addr 0..5, one done pulse, busy then 0.
- train step cap 3 with 3 samples and steps_per_sample=2 -> train ends after sample 2's first step; out_wen count for train = 3.
- num_init_samples=0 -> init skipped; first sample_req is at phase=2 with sample_addr=0.
- start pulsed again mid-run -> ignored; counts and addresses unchanged, single done.
- Deassert S_AXI_ARESETN during STEP with step_en=1 -> all outputs 0 asynchronously; no done; a new start runs from sample_addr 0.
- All counts 0 -> busy high for 4 cycles (3 SEL skips plus DONE), done pulses, no requests issued.
